screen_mem_arbiter: RTL and testbench

SCREEN_MEM_ARBITER -- requirements
Module: screen_mem_arbiter

---
 rtl/screen_mem_arbiter_pkg.sv | 8 +
 rtl/screen_mem_arbiter_rr.sv | 23 ++
 rtl/screen_mem_arbiter.sv | 77 +++++++
 tb/tb_screen_mem_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/screen_mem_arbiter_pkg.sv
// screen_mem_arbiter_pkg: shared screen-memory widths, FSM encodings and grant owner codes
package screen_mem_arbiter_pkg;
  localparam int SCR_ADDR_W = 11;
  localparam int SCR_DATA_W = 16;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_READWAIT} state_t;
  localparam logic LG_VGA = 1'b0;
  localparam logic LG_CPU = 1'b1;
endpackage

// File: rtl/screen_mem_arbiter_rr.sv
// rr_arbiter2: two-way round-robin grant (bit0 = VGA, bit1 = CPU) with last-grant memory
module rr_arbiter2
  import screen_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       busy,
  input  logic       upd,
  output logic [1:0] grant,
  output logic       last_grant
);
  logic last_q, last_d;
  always_comb begin
    grant = busy ? 2'b00 : (req == 2'b11) ? ((last_q == LG_CPU) ? 2'b01 : 2'b10) : req;
    last_d = upd ? grant[1] : last_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) last_q <= LG_CPU;
    else last_q <= last_d;
  end
  assign last_grant = last_q;
endmodule

// File: rtl/screen_mem_arbiter.sv
// screen_mem_arbiter: shares one external screen-memory port between VGA fetches and CPU accesses
module screen_mem_arbiter
  import screen_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = SCR_ADDR_W,
  parameter int DATA_W = SCR_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t state_q, state_d;
  logic mem_en_q, mem_we_q, vga_valid_q, cpu_ack_q, owner;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, vga_data_q, cpu_rdata_q;
  logic [1:0] pend, grant;
  // a requester completing this cycle is not pending, so a held request is not re-served
  assign pend = {cpu_req & ~cpu_ack_q, vga_req & ~vga_valid_q};
  rr_arbiter2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (pend),
    .busy      (state_q != S_IDLE),
    .upd       (|grant),
    .grant     (grant),
    .last_grant(owner)
  );
  always_comb begin
    state_d = (state_q == S_IDLE) ? (|grant ? S_ACCESS : S_IDLE)
            : (state_q == S_ACCESS && !mem_we_q) ? S_READWAIT : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      vga_valid_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      vga_data_q  <= '0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= |grant;
      mem_we_q    <= grant[1] & cpu_we;
      vga_valid_q <= (state_q == S_READWAIT) && owner == LG_VGA;
      cpu_ack_q   <= ((state_q == S_READWAIT) && owner == LG_CPU) || ((state_q == S_ACCESS) && mem_we_q);
      if (|grant) mem_addr_q <= grant[1] ? cpu_addr : vga_addr;
      if (grant[1] && cpu_we) mem_wdata_q <= cpu_wdata;
      if (state_q == S_READWAIT && owner == LG_VGA) vga_data_q <= mem_rdata;
      if (state_q == S_READWAIT && owner == LG_CPU) cpu_rdata_q <= mem_rdata;
    end
  end
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign vga_valid = vga_valid_q;
  assign vga_data  = vga_data_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
endmodule

// File: tb/tb_screen_mem_arbiter.sv
// tb_screen_mem_arbiter: directed table-driven bench with an external memory model
module tb_screen_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic vga_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [10:0] vga_addr = '0, cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] vga_data, cpu_rdata, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic vga_valid, cpu_ack, mem_en, mem_we;
  logic [10:0] mem_addr;
  logic [15:0] mem [0:2047];
  int checks = 0, errors = 0;

  typedef struct {
    logic        cpu;
    logic        we;
    logic [10:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
    int          lat;
    int          hold;
    logic        early;
  } vec_t;
  vec_t vecs [8];

  screen_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data), .vga_valid(vga_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("valid_ack_exclusive", {31'd0, vga_valid & cpu_ack}, 32'd0);
      chk("we_only_with_en", {31'd0, mem_we & ~mem_en}, 32'd0);
    end
  end

  task automatic run_txn(input vec_t v, input int idx);
    int done_at, n_en, n_done;
    done_at = -1; n_en = 0; n_done = 0;
    @(negedge clk);
    if (v.cpu) begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end else begin
      vga_req = 1'b1; vga_addr = v.addr;
    end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (mem_en) begin
        n_en++;
        chk($sformatf("v%0d_mem_addr", idx), {21'd0, mem_addr}, {21'd0, v.addr});
        chk($sformatf("v%0d_mem_we", idx), {31'd0, mem_we}, {31'd0, v.we});
        if (v.we) chk($sformatf("v%0d_mem_wdata", idx), {16'd0, mem_wdata}, {16'd0, v.wdata});
        if (v.early) begin vga_req = 1'b0; cpu_req = 1'b0; end
      end
      if (v.cpu ? cpu_ack : vga_valid) begin
        n_done++;
        if (done_at < 0) done_at = k;
        if (!v.we) chk($sformatf("v%0d_rdata", idx), {16'd0, v.cpu ? cpu_rdata : vga_data}, {16'd0, v.exp});
      end
      if (done_at > 0 && k == done_at + v.hold) begin vga_req = 1'b0; cpu_req = 1'b0; end
    end
    vga_req = 1'b0; cpu_req = 1'b0;
    chk($sformatf("v%0d_latency", idx), done_at - 1, v.lat);
    chk($sformatf("v%0d_grants", idx), n_en, 1);
    chk($sformatf("v%0d_completions", idx), n_done, 1);
  endtask

  initial begin
    int g, nv, nc;
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    mem[11'h200] = 16'hA5A5;
    mem[11'h300] = 16'hC3C3;
    mem[11'h000] = 16'h1111;
    //              cpu  we    addr    wdata     exp       lat hold early
    vecs[0] = '{1'b0, 1'b0, 11'h200, 16'h0000, 16'hA5A5, 2, 0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 11'h205, 16'h1234, 16'h0000, 1, 0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 11'h205, 16'h0000, 16'h1234, 2, 0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 11'h205, 16'h0000, 16'h1234, 2, 1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 11'h7FF, 16'hBEEF, 16'h0000, 1, 1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 11'h7FF, 16'h0000, 16'hBEEF, 2, 1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 11'h000, 16'h0000, 16'h1111, 2, 0, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 11'h300, 16'h0000, 16'hC3C3, 2, 0, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_mem_en", {31'd0, mem_en}, 0);
    chk("rst_mem_we", {31'd0, mem_we}, 0);
    chk("rst_valid_ack", {30'd0, vga_valid, cpu_ack}, 0);
    chk("rst_mem_addr", {21'd0, mem_addr}, 0);
    chk("rst_data", {vga_data, cpu_rdata}, 0);
    chk("rst_wdata", {16'd0, mem_wdata}, 0);
    reset = 1'b1;

    // simultaneous requests after reset: VGA first, then strict alternation
    @(negedge clk);
    vga_req = 1'b1; vga_addr = 11'h200; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h300;
    g = 0; nv = 0; nc = 0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (mem_en) begin
        if (g < 6) begin
          chk($sformatf("tie_cycle%0d", g), k, 1 + 3 * g);
          chk($sformatf("tie_addr%0d", g), {21'd0, mem_addr}, (g % 2) ? 32'h300 : 32'h200);
        end
        g++;
      end
      if (vga_valid) begin nv++; chk("tie_vga_data", {16'd0, vga_data}, 32'hA5A5); end
      if (cpu_ack) begin nc++; chk("tie_cpu_rdata", {16'd0, cpu_rdata}, 32'hC3C3); end
      if (k == 16) begin vga_req = 1'b0; cpu_req = 1'b0; end
    end
    chk("tie_grants", g, 6);
    chk("tie_vga_count", nv, 3);
    chk("tie_cpu_count", nc, 3);

    for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

    // reset during READWAIT of a CPU read aborts it
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h300;
    @(negedge clk);
    chk("rw_rst_access", {31'd0, mem_en}, 1);
    @(negedge clk);
    reset = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    chk("rw_rst_ctrl", {28'd0, mem_en, mem_we, vga_valid, cpu_ack}, 0);
    chk("rw_rst_addr", {21'd0, mem_addr}, 0);
    chk("rw_rst_data", {vga_data, cpu_rdata}, 0);
    chk("rw_rst_wdata", {16'd0, mem_wdata}, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rw_rst_no_ack", {30'd0, cpu_ack, mem_en}, 0);
    vga_req = 1'b1; vga_addr = 11'h200; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h300;
    @(negedge clk);
    chk("post_rst_grant_en", {31'd0, mem_en}, 1);
    chk("post_rst_grant_vga", {21'd0, mem_addr}, 32'h200);
    cpu_req = 1'b0; vga_req = 1'b0;
    nv = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (vga_valid) nv++;
    end
    chk("post_rst_vga_done", nv, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
